// File: rtl/qc_ldpc_pkg.sv
// Shared types and helpers for the QC-LDPC encoder sequencer.
// Holds the FSM state type and one-hot / address-width utilities.
package qc_ldpc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_HOLD
  } seq_state_e;

  function automatic int addr_w(input int nz, input int nb);
    return (nz * nb > 1) ? $clog2(nz * nb) : 1;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/qc_ldpc_lat_pipe.sv
// Valid+data delay line matching the shift-ROM read latency.
// LAT+1 register stages; a single stage when LAT is zero.
module qc_ldpc_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 81
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d,
  output logic         pend
);

  logic [LAT:0]        v_q;
  logic [LAT:0][W-1:0] d_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= in_v;
      d_q[0] <= in_v ? in_d : '0;
      for (int i = 1; i <= LAT; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_v = v_q[LAT];
  assign out_d = d_q[LAT];

  // pend: a beat is still travelling toward the output stage
  generate
    if (LAT == 0) begin : g_nopend
      assign pend = 1'b0;
    end else begin : g_pend
      assign pend = |v_q[LAT-1:0];
    end
  endgenerate

endmodule

// File: rtl/qc_ldpc_enc_sequencer.sv
// QC-LDPC encoder control: accepts a code-block request, streams
// info blocks with ROM addressing and drives accumulator strobes.
module qc_ldpc_enc_sequencer
  import qc_ldpc_pkg::*;
#(
  parameter int NUM_Z         = 3,
  parameter int MAX_Z         = 81,
  parameter int NUM_INFO_BLKS = 20,
  parameter int ROM_LAT       = 1,
  parameter int ADDRW         = addr_w(NUM_Z, NUM_INFO_BLKS)
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_Z-1:0]         req_z,
  output logic                     busy,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAX_Z-1:0]         info_in,
  output logic [MAX_Z-1:0]         info_out,
  output logic [ADDRW-1:0]         rom_addr,
  output logic [$clog2(NUM_Z)-1:0] z_idx,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int ZW = $clog2(NUM_Z);
  localparam int CW = $clog2(NUM_INFO_BLKS);
  localparam logic [CW-1:0] LAST = CW'(NUM_INFO_BLKS - 1);

  seq_state_e     state_q;
  logic [CW-1:0]  col_q;
  logic [ADDRW-1:0] rom_addr_q;
  logic [ZW-1:0]  z_idx_q;
  logic           busy_q;
  logic           cfg_err_q;
  logic           in_ready_q;
  logic           acc_clr_q;
  logic           out_valid_q;

  logic [31:0]    req_ext;
  logic [ZW-1:0]  zi;
  logic [ADDRW-1:0] base;
  logic           hs;
  logic           pend;

  assign req_ext = 32'(req_z);
  assign zi      = ZW'(onehot_to_idx(req_ext));
  assign base    = ADDRW'(zi) * ADDRW'(NUM_INFO_BLKS);
  assign hs      = (state_q == S_FILL) & in_valid & in_ready_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      rom_addr_q  <= '0;
      z_idx_q     <= '0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      acc_clr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_onehot(req_ext)) begin
              state_q    <= S_FILL;
              z_idx_q    <= zi;
              col_q      <= '0;
              rom_addr_q <= base;
              acc_clr_q  <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (hs) begin
            if (col_q == LAST) begin
              in_ready_q <= 1'b0;
              state_q    <= (ROM_LAT == 0) ? S_HOLD : S_DRAIN;
            end else begin
              col_q      <= col_q + CW'(1);
              rom_addr_q <= rom_addr_q + ADDRW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (acc_en && !pend) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // direct FILL->HOLD entry still lets the last acc_en settle first
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  qc_ldpc_lat_pipe #(
    .LAT (ROM_LAT),
    .W   (MAX_Z)
  ) u_pipe (
    .CLK   (CLK),
    .rst_n (rst_n),
    .in_v  (hs),
    .in_d  (info_in),
    .out_v (acc_en),
    .out_d (info_out),
    .pend  (pend)
  );

  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign in_ready  = in_ready_q;
  assign rom_addr  = rom_addr_q;
  assign z_idx     = z_idx_q;
  assign acc_clr   = acc_clr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_qc_ldpc_enc_sequencer.sv
// Directed bench for qc_ldpc_enc_sequencer (ROM_LAT=1 and 0).
// Inputs change 1ns after each rising edge; outputs are read then.
module tb_qc_ldpc_enc_sequencer;

  logic        CLK;
  logic        rst_n;

  logic        start, in_valid, out_ready;
  logic [2:0]  req_z;
  logic [80:0] info_in, info_out;
  logic        busy, cfg_err, in_ready, acc_clr, acc_en, out_valid;
  logic [5:0]  rom_addr;
  logic [1:0]  z_idx;

  logic        start0, in_valid0, out_ready0;
  logic [2:0]  req_z0;
  logic [80:0] info_in0, info_out0;
  logic        busy0, cfg_err0, in_ready0, acc_clr0, acc_en0, out_valid0;
  logic [5:0]  rom_addr0;
  logic [1:0]  z_idx0;

  int n_checks = 0;
  int n_fail   = 0;
  bit hs[64];

  qc_ldpc_enc_sequencer dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .req_z(req_z),
    .busy(busy), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .info_in(info_in), .info_out(info_out),
    .rom_addr(rom_addr), .z_idx(z_idx), .acc_clr(acc_clr),
    .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready)
  );

  qc_ldpc_enc_sequencer #(.ROM_LAT(0)) dut0 (
    .CLK(CLK), .rst_n(rst_n), .start(start0), .req_z(req_z0),
    .busy(busy0), .cfg_err(cfg_err0), .in_valid(in_valid0),
    .in_ready(in_ready0), .info_in(info_in0), .info_out(info_out0),
    .rom_addr(rom_addr0), .z_idx(z_idx0), .acc_clr(acc_clr0),
    .acc_en(acc_en0), .out_valid(out_valid0), .out_ready(out_ready0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [80:0] pat(input int s);
    return {17'(s), 32'hC0DE_0000 | 32'(s), 32'(s * 13)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; in_valid = 0; out_ready = 0; req_z = '0; info_in = '0;
    start0 = 0; in_valid0 = 0; out_ready0 = 0; req_z0 = '0; info_in0 = '0;
    #1;
    step();
    n_checks++;
    if ({busy, cfg_err, in_ready, acc_clr, acc_en, out_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, cfg_err, in_ready, acc_clr, acc_en, out_valid});
    end
    n_checks++;
    if ({rom_addr, z_idx} !== 8'h0 || info_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %0d z %0d info %h want 0",
               rom_addr, z_idx, info_out);
    end
    n_checks++;
    if ({busy0, in_ready0, acc_en0, out_valid0, acc_clr0} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_lat0: got %b want 00000",
               {busy0, in_ready0, acc_en0, out_valid0, acc_clr0});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    logic       e_ae;
    logic [80:0] e_io;
    logic [5:0] e_ad;
    out_ready = 1'b1;
    req_z = 3'b010;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s <= 25; s++) begin
      e_ae = (s >= 3 && s <= 22);
      e_io = e_ae ? pat(s - 2) : '0;
      e_ad = (s <= 20) ? 6'(19 + s) : 6'd39;
      n_checks++;
      if (acc_en !== e_ae) begin
        n_fail++;
        $display("FAIL nom_acc_en s%0d: got %b want %b", s, acc_en, e_ae);
      end
      n_checks++;
      if (info_out !== e_io) begin
        n_fail++;
        $display("FAIL nom_info s%0d: got %h want %h", s, info_out, e_io);
      end
      n_checks++;
      if (acc_clr !== (s == 1)) begin
        n_fail++;
        $display("FAIL nom_acc_clr s%0d: got %b", s, acc_clr);
      end
      n_checks++;
      if (out_valid !== (s == 23)) begin
        n_fail++;
        $display("FAIL nom_out_valid s%0d: got %b", s, out_valid);
      end
      n_checks++;
      if (busy !== (s <= 23)) begin
        n_fail++;
        $display("FAIL nom_busy s%0d: got %b", s, busy);
      end
      n_checks++;
      if (in_ready !== (s <= 20)) begin
        n_fail++;
        $display("FAIL nom_in_ready s%0d: got %b", s, in_ready);
      end
      n_checks++;
      if (rom_addr !== e_ad) begin
        n_fail++;
        $display("FAIL nom_rom_addr s%0d: got %0d want %0d", s, rom_addr, e_ad);
      end
      n_checks++;
      if (z_idx !== 2'd1) begin
        n_fail++;
        $display("FAIL nom_z_idx s%0d: got %0d want 1", s, z_idx);
      end
      in_valid = (s <= 20);
      info_in = pat(s);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_invalid();
    logic [2:0] bad [2];
    bad[0] = 3'b000;
    bad[1] = 3'b101;
    for (int i = 0; i < 2; i++) begin
      req_z = bad[i];
      start = 1'b1;
      step();
      n_checks++;
      if (cfg_err !== 1'b1) begin
        n_fail++;
        $display("FAIL inv_cfg_err %b: got %b want 1", bad[i], cfg_err);
      end
      n_checks++;
      if ({busy, acc_clr, in_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL inv_quiet %b: busy/clr/rdy %b want 000",
                 bad[i], {busy, acc_clr, in_ready});
      end
      n_checks++;
      if (z_idx !== 2'd1 || rom_addr !== 6'd39) begin
        n_fail++;
        $display("FAIL inv_hold %b: z %0d addr %0d want 1 39",
                 bad[i], z_idx, rom_addr);
      end
    end
    start = 1'b0;
    step();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_cfg_err_drop: got %b want 0", cfg_err);
    end
  endtask

  task automatic test_backpressure();
    int         beats;
    logic       v, e_ae;
    logic [80:0] e_io;
    logic [5:0] e_ad;
    for (int i = 0; i < 64; i++) hs[i] = 1'b0;
    beats = 0;
    out_ready = 1'b0;
    req_z = 3'b001;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s <= 32; s++) begin
      v = (s == 1) || (s >= 4 && s <= 22);
      e_ae = (s >= 3) && hs[s-2];
      e_io = e_ae ? pat(s - 2) : '0;
      e_ad = (beats > 19) ? 6'd19 : 6'(beats);
      n_checks++;
      if (rom_addr !== e_ad) begin
        n_fail++;
        $display("FAIL bp_rom_addr s%0d: got %0d want %0d", s, rom_addr, e_ad);
      end
      n_checks++;
      if (in_ready !== (s <= 22)) begin
        n_fail++;
        $display("FAIL bp_in_ready s%0d: got %b", s, in_ready);
      end
      n_checks++;
      if (acc_en !== e_ae || info_out !== e_io) begin
        n_fail++;
        $display("FAIL bp_acc s%0d: en %b info %h want %b %h",
                 s, acc_en, info_out, e_ae, e_io);
      end
      n_checks++;
      if (out_valid !== (s >= 25 && s <= 30)) begin
        n_fail++;
        $display("FAIL bp_out_valid s%0d: got %b", s, out_valid);
      end
      n_checks++;
      if (busy !== (s <= 30) || acc_clr !== (s == 1)) begin
        n_fail++;
        $display("FAIL bp_busy_clr s%0d: busy %b clr %b", s, busy, acc_clr);
      end
      n_checks++;
      if (z_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_z_idx s%0d: got %0d want 0", s, z_idx);
      end
      start = (s == 2 || s == 23 || s == 26);
      req_z = start ? 3'b100 : 3'b001;
      out_ready = (s >= 30);
      in_valid = v;
      info_in = pat(s);
      hs[s] = v && (s <= 22);
      if (hs[s]) beats++;
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midblock();
    bit act;
    bit seen;
    out_ready = 1'b1;
    req_z = 3'b100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      n_checks++;
      if (rom_addr !== 6'(39 + s)) begin
        n_fail++;
        $display("FAIL rst_pre_addr s%0d: got %0d want %0d", s, rom_addr, 39 + s);
      end
      in_valid = 1'b1;
      info_in = pat(s);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc_en !== 1'b1 || info_out !== pat(6)) begin
      n_fail++;
      $display("FAIL rst_pre_acc: en %b info %h", acc_en, info_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, cfg_err, in_ready, acc_clr, acc_en, out_valid} !== 6'b0 ||
        rom_addr !== 6'd0 || z_idx !== 2'd0 || info_out !== '0) begin
      n_fail++;
      $display("FAIL rst_abort: flags %b addr %0d z %0d",
               {busy, cfg_err, in_ready, acc_clr, acc_en, out_valid},
               rom_addr, z_idx);
    end
    step();
    step();
    rst_n = 1'b1;
    act = 1'b0;
    in_valid = 1'b1;
    for (int s = 0; s < 30; s++) begin
      if (acc_en || out_valid || busy || in_ready) act = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (act !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_activity: got activity 1 want 0");
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (rom_addr !== 6'd40 || z_idx !== 2'd2 || acc_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart: addr %0d z %0d clr %b want 40 2 1",
               rom_addr, z_idx, acc_clr);
    end
    in_valid = 1'b1;
    for (int s = 0; s < 20; s++) step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int s = 0; s < 10 && !seen; s++) begin
      if (out_valid) seen = 1'b1;
      else step();
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart_done: out_valid not seen within 10 cycles");
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic       v, e_ae;
    logic [80:0] e_io;
    logic [5:0] e_ad;
    logic [1:0] e_z;
    for (int i = 0; i < 64; i++) hs[i] = 1'b0;
    out_ready0 = 1'b1;
    n_checks++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy0 %b want 0", busy0);
    end
    req_z0 = 3'b001;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int s = 1; s <= 47; s++) begin
      v = (s >= 1 && s <= 20) || (s >= 24 && s <= 43);
      e_ae = hs[s-1];
      e_io = e_ae ? pat(s - 1) : '0;
      if (s <= 20) e_ad = 6'(s - 1);
      else if (s <= 23) e_ad = 6'd19;
      else if (s <= 43) e_ad = 6'(40 + s - 24);
      else e_ad = 6'd59;
      e_z = (s < 24) ? 2'd0 : 2'd2;
      n_checks++;
      if (acc_en0 !== e_ae || info_out0 !== e_io) begin
        n_fail++;
        $display("FAIL b2b_acc s%0d: en %b info %h want %b %h",
                 s, acc_en0, info_out0, e_ae, e_io);
      end
      n_checks++;
      if (acc_clr0 !== (s == 1 || s == 24) || (acc_clr0 && acc_en0)) begin
        n_fail++;
        $display("FAIL b2b_acc_clr s%0d: clr %b en %b", s, acc_clr0, acc_en0);
      end
      n_checks++;
      if (out_valid0 !== (s == 22 || s == 45)) begin
        n_fail++;
        $display("FAIL b2b_out_valid s%0d: got %b", s, out_valid0);
      end
      n_checks++;
      if (busy0 !== !(s == 23 || s >= 46) || in_ready0 !== v) begin
        n_fail++;
        $display("FAIL b2b_busy_rdy s%0d: busy %b rdy %b", s, busy0, in_ready0);
      end
      n_checks++;
      if (rom_addr0 !== e_ad || z_idx0 !== e_z) begin
        n_fail++;
        $display("FAIL b2b_addr s%0d: addr %0d z %0d want %0d %0d",
                 s, rom_addr0, z_idx0, e_ad, e_z);
      end
      start0 = (s == 23);
      req_z0 = (s >= 23) ? 3'b100 : 3'b001;
      in_valid0 = v;
      info_in0 = pat(s);
      hs[s] = v;
      step();
    end
    start0 = 1'b0;
    in_valid0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_invalid();
    test_backpressure();
    test_reset_midblock();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qc_ldpc_enc_sequencer.md
# qc_ldpc_enc_sequencer

Control sequencer for the QC-LDPC encoder datapath. It accepts one code-block request with a one-hot lifting-size select, then streams exactly NUM_INFO_BLKS info blocks into the encoder under a valid/ready handshake. For each accepted block it drives the prototype-matrix shift ROM address, aligns the info data with the ROM read latency, and issues accumulator clear/enable strobes. When the accumulation completes it presents parity-valid to the downstream consumer and holds it until that consumer acknowledges.

## Interface
- NUM_Z, 3, number of supported lifting sizes
- MAX_Z, 81, info block width in bits
- NUM_INFO_BLKS, 20, info blocks (proto-matrix columns) per code block
- ROM_LAT, 1, shift-ROM read latency in cycles (0..3)
- ADDRW, $clog2(NUM_Z*NUM_INFO_BLKS), ROM address width (derived)
- CLK  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  code-block request; sampled only in IDLE
- req_z  in  NUM_Z  one-hot lifting-size select, sampled with start
- busy  out  1  high in every state except IDLE
- cfg_err  out  1  one-cycle pulse when start is rejected
- in_valid  in  1  info block valid
- in_ready  out  1  sequencer accepts info block
- info_in  in  MAX_Z  info block data
- info_out  out  MAX_Z  info data delayed ROM_LAT cycles, aligned with acc_en
- rom_addr  out  ADDRW  shift-ROM address = z_idx*NUM_INFO_BLKS + col
- z_idx  out  $clog2(NUM_Z)  binary index of the latched req_z
- acc_clr  out  1  clear the parity accumulators
- acc_en  out  1  accumulate rotated info_out into the parity registers
- out_valid  out  1  parity blocks complete and stable
- out_ready  in  1  downstream has consumed the parity blocks

## Operation
- States: IDLE, FILL, DRAIN, HOLD.
- IDLE behaviour on start:
  - If req_z is one-hot: latch z_idx, clear col, assert acc_clr for one cycle, and go to FILL.
  - If req_z is not one-hot (zero or multi-hot): pulse cfg_err, stay in IDLE, and change no other output.
- FILL:
  - in_ready = 1.
  - A handshake (in_valid & in_ready) samples rom_addr for the current col, increments col, and pushes info_in plus a valid bit into a ROM_LAT-deep delay line.
  - On the handshake with col = NUM_INFO_BLKS-1, go to DRAIN, or directly to HOLD when ROM_LAT = 0.
- rom_addr changes only on a handshake or on start acceptance, so it is stable while in_valid is low.
- acc_en is the delay-line valid output; info_out is the delay-line data output.
- DRAIN:
  - in_ready = 0.
  - Wait until the final delayed acc_en has fired, then go to HOLD on the next cycle.
- HOLD:
  - out_valid = 1 and in_ready = 0.
  - When out_ready is high, go to IDLE the following cycle.
  - start is ignored in HOLD.
- Invariants:
  - acc_clr and acc_en are never high in the same cycle.
  - Exactly NUM_INFO_BLKS acc_en pulses occur per code block.
  - z_idx is constant from start acceptance until the return to IDLE.
- col width is $clog2(NUM_INFO_BLKS). col never wraps past NUM_INFO_BLKS-1; it is cleared on start.
- rom_addr is computed at ADDRW width with no truncation. The maximum address is NUM_Z*NUM_INFO_BLKS-1.
- start, in_valid and out_ready are don't-care in any state where they are not sampled.

## Timing
- Reset values:
  - state = IDLE.
  - busy, cfg_err, in_ready, acc_clr, acc_en, out_valid = 0.
  - rom_addr, z_idx, info_out = 0.
  - The delay line is cleared.
- Reset mid-block aborts the block immediately: no further acc_en and no out_valid.
- start accepted at cycle t: acc_clr and busy are high at t+1, and in_ready is high from t+1.
- A handshake at cycle k produces acc_en and info_out at k+1+ROM_LAT. These outputs are registered, so with ROM_LAT = 0 they appear at k+1.
- out_valid rises 1 cycle after the last acc_en.
- Minimum block length: 1 (clear) + NUM_INFO_BLKS + ROM_LAT + 1 cycles to out_valid.
- out_valid & out_ready at cycle h: IDLE and busy = 0 at h+1. A start at h+1 is accepted.
- Back-pressure: in_valid gaps stall col and rom_addr. The delay line keeps shifting, so the acc_en pulses show the gaps.

## Structure
- Shared package qc_ldpc_pkg holds:
  - the state enum type;
  - the function onehot_to_idx;
  - the function is_onehot;
  - the ROM address-width constant function.
- One sub-module, qc_ldpc_lat_pipe: a parameterised ROM_LAT-deep valid+data delay line with async reset. It degenerates to a single register stage when ROM_LAT = 0.
- The FSM, col counter and address generation live in qc_ldpc_enc_sequencer.

## Test plan
- Nominal block: req_z = 3'b010, start, 20 back-to-back beats, out_ready held high.
  - z_idx = 1; rom_addr runs 20..39.
  - 20 acc_en pulses, each 2 cycles after its beat.
  - out_valid for exactly 1 cycle.
- Invalid select: req_z = 3'b000 and then 3'b101 with start.
  - cfg_err pulses each time; busy stays 0; no acc_clr.
- Back-pressure: in_valid toggles 1,0,0,1 and out_ready is held low for 5 cycles.
  - rom_addr holds during the gaps.
  - out_valid stays high for all 5 cycles; in_ready stays 0 while out_valid is high.
- Reset mid-block: assert rst_n low after beat 7 of a z_idx = 2 block.
  - All outputs return to 0 at once; no out_valid.
  - A new block after reset starts with rom_addr = 40 (z_idx = 2) or 0 (z_idx = 0).
- Back-to-back blocks with ROM_LAT = 0:
  - start in the cycle after the handshake is accepted.
  - acc_en appears 1 cycle after each beat.
  - No overlap of acc_clr with acc_en.
- start asserted during FILL, DRAIN and HOLD:
  - ignored; z_idx and col are unchanged.
